// File: rtl/rr_arbiter_lock.sv
// rr_arbiter_lock: N-channel round-robin arbiter with a locked grant.
// A winner is chosen from req starting at the one-hot priority pointer and
// searching upward with wraparound. The grant is held until the holder
// pulses done or drops its request. The pointer then moves just past the
// holder. One idle cycle always separates consecutive grants.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   req        in   [N-1:0] per-channel request levels
//   done       in   holder release pulse
//   gnt        out  [N-1:0] registered one-hot grant
//   gnt_valid  out  high while a grant is held
//   gnt_id     out  [IDW-1:0] binary index of the holder, 0 when idle
//   ptr        out  [N-1:0] one-hot priority pointer
//   timeout    out  one-cycle pulse on a forced release
//
// Optional macro RR_ARB_TIMEOUT_EN: limits a grant to TIMEOUT cycles.
// Without it, timeout is tied to 0 and no counter is built.

module rr_arbiter_lock #(
    parameter int N       = 4,
    parameter int IDW     = $clog2(N),
    parameter int TIMEOUT = 255
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic [N-1:0]   ptr,
    output logic           timeout
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]     r_state;
    logic [N-1:0]   r_gnt;
    logic           r_valid;
    logic [IDW-1:0] r_gnt_id;
    logic [N-1:0]   r_ptr;
    logic           r_timeout;

    logic [IDW-1:0] w_ptr_idx;
    logic [2*N-1:0] w_req_dbl;
    logic [N-1:0]   w_req_rot;
    logic [IDW-1:0] w_off;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_win_idx;
    logic [N-1:0]   w_win_oh;
    logic [N-1:0]   w_ptr_next;
    logic           w_norm_rel;
    logic           w_force;
    logic           w_release;

    // Binary index of the pointer bit.
    always_comb begin
        w_ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (r_ptr[i]) w_ptr_idx = IDW'(i);
        end
    end

    // Rotate req so the pointer channel lands at bit 0; the lowest set
    // bit of the rotated vector is then the offset of the winner.
    assign w_req_dbl = {req, req} >> w_ptr_idx;
    assign w_req_rot = w_req_dbl[N-1:0];

    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req_rot[i]) w_off = IDW'(i);
        end
    end

    // Undo the rotation: (pointer + offset) mod N.
    always_comb begin
        w_sum = {1'b0, w_ptr_idx} + {1'b0, w_off};
        if (w_sum >= (IDW+1)'(N)) w_sum = w_sum - (IDW+1)'(N);
    end

    assign w_win_idx = w_sum[IDW-1:0];
    assign w_win_oh  = N'(1) << w_win_idx;

    // Next pointer: one past the holder, wrapping N-1 to 0.
    assign w_ptr_next = {r_gnt[N-2:0], r_gnt[N-1]};

    assign w_norm_rel = done | ~(|(req & r_gnt));

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Zero on the first grant cycle; a forced release follows the cycle
    // where it reads TIMEOUT-1, giving exactly TIMEOUT grant cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_force = (r_state == S_GRANT) && (r_cnt == TO_LAST)
                     && !w_norm_rel;
`else
    assign w_force = 1'b0;
`endif

    assign w_release = w_norm_rel | w_force;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_valid   <= 1'b0;
            r_gnt_id  <= '0;
            r_ptr     <= N'(1);
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state  <= S_GRANT;
                        r_gnt    <= w_win_oh;
                        r_valid  <= 1'b1;
                        r_gnt_id <= w_win_idx;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state   <= S_IDLE;
                        r_gnt     <= '0;
                        r_valid   <= 1'b0;
                        r_gnt_id  <= '0;
                        r_ptr     <= w_ptr_next;
                        r_timeout <= w_force;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_valid;
    assign gnt_id    = r_gnt_id;
    assign ptr       = r_ptr;
    assign timeout   = r_timeout;

    a_gnt_onehot0: assert property (
        @(posedge clock) disable iff (!reset) $onehot0(r_gnt));

    a_ptr_onehot: assert property (
        @(posedge clock) disable iff (!reset) $onehot(r_ptr));

    a_gnt_id: assert property (
        @(posedge clock) disable iff (!reset)
        r_valid ? r_gnt[r_gnt_id] : (r_gnt_id == '0));

    a_valid: assert property (
        @(posedge clock) disable iff (!reset) r_valid == (|r_gnt));

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// tb_rr_arbiter_lock: directed and random stimulus for rr_arbiter_lock,
// checked every cycle against a holder/pointer-index reference model.

module tb_rr_arbiter_lock;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TMO = 8;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req   = '0;
    logic           done  = 1'b0;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   ptr;
    logic           timeout;

    int n_chk = 0;
    int n_err = 0;

    rr_arbiter_lock #(
        .N       (N),
        .IDW     (IDW),
        .TIMEOUT (TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .ptr       (ptr),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    // Reference model: holder index (-1 = none), pointer index,
    // cycles the current grant has been held, expected timeout pulse.
    int m_holder;
    int m_pidx;
    int m_held;
    bit m_to;

    function automatic logic [N-1:0] oh(input int i);
        if (i < 0) return '0;
        return N'(1) << i;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if ((r & oh((p + k) % N)) != '0) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clock or negedge reset) begin : mdl
        int h, p, c;
        bit t, rel, frc;
        if (!reset) begin
            m_holder <= -1;
            m_pidx   <= 0;
            m_held   <= 0;
            m_to     <= 1'b0;
        end else begin
            h = m_holder;
            p = m_pidx;
            c = m_held;
            t = 1'b0;
            if (h < 0) begin
                if (req != '0) begin
                    h = pick(req, p);
                    c = 1;
                end
            end else begin
                rel = done || ((req & oh(h)) == '0);
                frc = TO_EN && !rel && (c == TMO);
                if (rel || frc) begin
                    p = (h + 1) % N;
                    h = -1;
                    t = frc;
                end else begin
                    c = c + 1;
                end
            end
            m_holder <= h;
            m_pidx   <= p;
            m_held   <= c;
            m_to     <= t;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("gnt", 32'(gnt), 32'(oh(m_holder)));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_holder >= 0));
        chk("gnt_id", 32'(gnt_id), (m_holder < 0) ? 0 : m_holder);
        chk("ptr", 32'(ptr), 32'(oh(m_pidx)));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    // Drive for one cycle from a falling edge, compare at the next one.
    task automatic step(input logic [N-1:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clock);
        @(negedge clock);
        cmp_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        done  = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        cmp_all();
    endtask

    logic [N-1:0] pseq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] r_rand;

    initial begin
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(gnt_valid), 32'h0);
        chk("rst_ptr", 32'(ptr), 32'h1);
        chk("rst_id", 32'(gnt_id), 32'h0);

        // All-ones rotation.
        step(4'b1111, 1'b0);
        chk("rot_g0", 32'(gnt), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 1'b1);
            chk("rot_bubble", 32'(gnt), 32'h0);
            chk("rot_ptr", 32'(ptr), 32'(pseq[i]));
            step(4'b1111, 1'b0);
            chk("rot_gnt", 32'(gnt), 32'(pseq[i]));
        end

        // Asynchronous reset mid-grant, between clock edges.
        #2 reset = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_ptr", 32'(ptr), 32'h1);
        chk("arst_valid", 32'(gnt_valid), 32'h0);
        cmp_all();
        @(negedge clock);
        req   = '0;
        reset = 1'b1;

        // Lock: later requests ignored until done.
        do_reset();
        step(4'b0100, 1'b0);
        chk("lock_g", 32'(gnt), 32'h4);
        step(4'b1110, 1'b0);
        chk("lock_hold", 32'(gnt), 32'h4);
        step(4'b1110, 1'b1);
        chk("lock_ptr", 32'(ptr), 32'h8);
        step(4'b1110, 1'b0);
        chk("lock_next", 32'(gnt), 32'h8);

        // Done and holder drop on the same edge.
        do_reset();
        step(4'b0010, 1'b0);
        chk("drop_g", 32'(gnt), 32'h2);
        step(4'b0101, 1'b1);
        chk("drop_ptr", 32'(ptr), 32'h4);
        chk("drop_bub", 32'(gnt), 32'h0);
        step(4'b0101, 1'b0);
        chk("drop_next", 32'(gnt), 32'h4);

        // done in IDLE ignored; wrap to channel 3.
        do_reset();
        step(4'b0000, 1'b1);
        chk("idle_ptr", 32'(ptr), 32'h1);
        chk("idle_gnt", 32'(gnt), 32'h0);
        step(4'b1000, 1'b0);
        chk("wrap_gnt", 32'(gnt), 32'h8);
        chk("wrap_id", 32'(gnt_id), 32'h3);

        // Persistent holder, no done.
        do_reset();
        step(4'b0011, 1'b0);
        chk("to_g1", 32'(gnt), 32'h1);
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 1; i < TMO; i++) begin
            step(4'b0011, 1'b0);
            chk("to_hold", 32'(gnt), 32'h1);
            chk("to_quiet", 32'(timeout), 32'h0);
        end
        step(4'b0011, 1'b0);
        chk("to_rel", 32'(gnt), 32'h0);
        chk("to_pulse", 32'(timeout), 32'h1);
        step(4'b0011, 1'b0);
        chk("to_next", 32'(gnt), 32'h2);
        chk("to_end", 32'(timeout), 32'h0);
`else
        for (int i = 1; i < TMO + 4; i++) begin
            step(4'b0011, 1'b0);
            chk("hold_g", 32'(gnt), 32'h1);
            chk("hold_to", 32'(timeout), 32'h0);
        end
`endif

        // Random stimulus.
        do_reset();
        r_rand = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r_rand = N'($urandom);
            if ($urandom_range(0, 15) == 0) r_rand = '0;
            step(r_rand, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 249) == 0) begin
                #2 reset = 1'b0;
                #1 cmp_all();
                @(negedge clock);
                reset = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
